// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the pipelined channel multiplexer.
//   state_e           - skid-buffer occupancy states (EMPTY/ONE/TWO)
//   OOR_VALUE_DEFAULT - word returned when the selector is out of range
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [31:0] OOR_VALUE_DEFAULT = 32'd227;

endpackage

// File: rtl/mux_pipe_n_if.sv
// mux_pipe_n_if: handshake bundle of the pipelined multiplexer.
//   data_in   - N_IN flattened channels, channel k at [k*DATA_W +: DATA_W]
//   selector  - channel index, sampled on accept
//   in_valid  - upstream request present
//   in_ready  - block can accept
//   data_out  - selected word
//   sel_err   - data_out came from an out-of-range selector
//   out_valid - data_out / sel_err valid
//   out_ready - downstream accepts
// master = producer/consumer side, slave = the multiplexer.
interface mux_pipe_n_if #(
  parameter int DATA_W = 32,
  parameter int N_IN   = 8,
  parameter int SEL_W  = $clog2(N_IN)
) ();

  logic [N_IN*DATA_W-1:0] data_in;
  logic [SEL_W-1:0]       selector;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      data_out;
  logic                   sel_err;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output data_in, selector, in_valid, out_ready,
    input  in_ready, data_out, sel_err, out_valid
  );

  modport slave (
    input  data_in, selector, in_valid, out_ready,
    output in_ready, data_out, sel_err, out_valid
  );

endinterface

// File: rtl/mux_sel_n.sv
// mux_sel_n: combinational channel select with range check.
//   data_in - flattened channels, channel k at [k*DATA_W +: DATA_W]
//   sel     - channel index
//   word    - channel[sel], or OOR_VALUE sized to DATA_W when sel >= N_IN
//   err     - 1 when sel >= N_IN
module mux_sel_n
  import mux_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          N_IN      = 8,
  parameter int          SEL_W     = $clog2(N_IN),
  parameter logic [31:0] OOR_VALUE = OOR_VALUE_DEFAULT
) (
  input  logic [N_IN*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]       sel,
  output logic [DATA_W-1:0]      word,
  output logic                   err
);

  // Scan all channels; a selector matching none of them is out of range.
  always_comb begin
    word = DATA_W'(OOR_VALUE);
    err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      word = (sel == SEL_W'(k)) ? data_in[k*DATA_W +: DATA_W] : word;
      err  = (sel == SEL_W'(k)) ? 1'b0 : err;
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: N-input multiplexer with a registered 2-entry skid buffer.
//   clk      - clock, all state on rising edge
//   reset_n  - synchronous active-low reset
//   bus      - mux_pipe_n_if.slave handshake bundle (instantiate the
//              interface with the same DATA_W/N_IN/SEL_W as this module)
//   scan_en  - only with MUX_PIPE_SCAN_EN defined: when 1 the selector is
//              ignored and an internal round-robin pointer picks the channel
// All outputs come straight from registers.
module mux_pipe_n
  import mux_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          N_IN      = 8,
  parameter int          SEL_W     = $clog2(N_IN),
  parameter logic [31:0] OOR_VALUE = OOR_VALUE_DEFAULT
) (
  input logic         clk,
  input logic         reset_n,
`ifdef MUX_PIPE_SCAN_EN
  input logic         scan_en,
`endif
  mux_pipe_n_if.slave bus
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] data_out_r;
  logic              sel_err_r;
  logic [DATA_W-1:0] skid_data_r;
  logic              skid_err_r;
  logic [SEL_W-1:0]  eff_sel_s;
  logic [DATA_W-1:0] sel_word_s;
  logic              sel_err_s;
  logic              accept_s;
  logic              transfer_s;

  assign accept_s   = bus.in_valid & in_ready_r;
  assign transfer_s = out_valid_r & bus.out_ready;

`ifdef MUX_PIPE_SCAN_EN
  logic [SEL_W-1:0] ptr_r;

  // Round-robin pointer: advances on each scan-mode accept, wraps at N_IN-1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_r <= {SEL_W{1'b0}};
    end else if (accept_s && scan_en) begin
      if (ptr_r == SEL_W'(N_IN - 1)) begin
        ptr_r <= {SEL_W{1'b0}};
      end else begin
        ptr_r <= ptr_r + SEL_W'(1);
      end
    end
  end

  // The pointer never exceeds N_IN-1, so scan mode cannot raise sel_err.
  assign eff_sel_s = scan_en ? ptr_r : bus.selector;
`else
  assign eff_sel_s = bus.selector;
`endif

  mux_sel_n #(
    .DATA_W   (DATA_W),
    .N_IN     (N_IN),
    .SEL_W    (SEL_W),
    .OOR_VALUE(OOR_VALUE)
  ) u_sel (
    .data_in(bus.data_in),
    .sel    (eff_sel_s),
    .word   (sel_word_s),
    .err    (sel_err_s)
  );

  // Next-state logic of the skid-buffer occupancy FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ONE;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && !transfer_s) begin
          state_nxt_s = TWO;
        end else if (!accept_s && transfer_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = ONE;
        end
      end
      TWO: begin
        // in_ready is low in TWO, so no accept can coincide here.
        if (transfer_s) begin
          state_nxt_s = ONE;
        end else begin
          state_nxt_s = TWO;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // State register plus flags derived from the next state so they are registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != TWO);
      out_valid_r <= (state_nxt_s != EMPTY);
    end
  end

  // Output and skid registers: new words land on the output when it is free
  // (or being drained this edge), otherwise in the skid entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out_r  <= {DATA_W{1'b0}};
      sel_err_r   <= 1'b0;
      skid_data_r <= {DATA_W{1'b0}};
      skid_err_r  <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            data_out_r <= sel_word_s;
            sel_err_r  <= sel_err_s;
          end
        end
        ONE: begin
          if (accept_s && transfer_s) begin
            data_out_r <= sel_word_s;
            sel_err_r  <= sel_err_s;
          end else if (accept_s) begin
            skid_data_r <= sel_word_s;
            skid_err_r  <= sel_err_s;
          end
        end
        TWO: begin
          if (transfer_s) begin
            data_out_r <= skid_data_r;
            sel_err_r  <= skid_err_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.data_out  = data_out_r;
  assign bus.sel_err   = sel_err_r;

endmodule

// File: tb/tb_mux_pipe_n.sv
// tb_mux_pipe_n: self-checking bench for mux_pipe_n.
// An 8-channel instance is tracked cycle by cycle by a queue model of the
// 2-deep buffer; a 6-channel instance covers out-of-range selectors.
// Scan-mode stimulus is included when MUX_PIPE_SCAN_EN is defined.
module tb_mux_pipe_n;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: queue of {sel_err, word} in accept order, depth <= 2.
  logic [DW:0] mq[$];
`ifdef MUX_PIPE_SCAN_EN
  logic scan_en;
  int   scan_ptr = 0;
`endif

  always #5 clk = ~clk;

  mux_pipe_n_if #(.DATA_W(DW), .N_IN(8), .SEL_W(3)) if8 ();
  mux_pipe_n_if #(.DATA_W(DW), .N_IN(6), .SEL_W(3)) if6 ();

  mux_pipe_n #(.DATA_W(DW), .N_IN(8), .SEL_W(3)) dut8 (
    .clk    (clk),
    .reset_n(reset_n),
`ifdef MUX_PIPE_SCAN_EN
    .scan_en(scan_en),
`endif
    .bus    (if8)
  );

  mux_pipe_n #(.DATA_W(DW), .N_IN(6), .SEL_W(3)) dut6 (
    .clk    (clk),
    .reset_n(reset_n),
`ifdef MUX_PIPE_SCAN_EN
    .scan_en(1'b0),
`endif
    .bus    (if6)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_chan8();
    for (int k = 0; k < 8; k++) if8.data_in[k*DW +: DW] = 32'h1000 + k;
  endtask

  // Advance one clock, update the model with what happened at the edge,
  // and compare the 8-channel instance against it.
  task automatic tick();
    logic        acc;
    logic        xfr;
    logic [DW:0] nw;
    int          sel;
    acc = reset_n && if8.in_valid && (mq.size() < 2);
    xfr = reset_n && if8.out_ready && (mq.size() > 0);
    sel = int'(if8.selector);
`ifdef MUX_PIPE_SCAN_EN
    if (scan_en) sel = scan_ptr;
`endif
    nw = (sel < 8) ? {1'b0, if8.data_in[sel*DW +: DW]} : {1'b1, 32'd227};
    @(posedge clk);
    if (!reset_n) begin
      mq.delete();
`ifdef MUX_PIPE_SCAN_EN
      scan_ptr = 0;
`endif
    end else begin
      if (xfr) void'(mq.pop_front());
      if (acc) mq.push_back(nw);
`ifdef MUX_PIPE_SCAN_EN
      if (acc && scan_en) scan_ptr = (scan_ptr + 1) % 8;
`endif
    end
    #1;
    check_eq("out_valid", {63'd0, if8.out_valid}, {63'd0, mq.size() > 0});
    check_eq("in_ready", {63'd0, if8.in_ready}, {63'd0, mq.size() < 2});
    if (mq.size() > 0) begin
      check_eq("data_out", {32'd0, if8.data_out}, {32'd0, mq[0][DW-1:0]});
      check_eq("sel_err", {63'd0, if8.sel_err}, {63'd0, mq[0][DW]});
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b0;
    if8.selector  = 3'd0;
    if6.in_valid  = 1'b0;
    if6.out_ready = 1'b1;
    if6.selector  = 3'd0;
`ifdef MUX_PIPE_SCAN_EN
    scan_en = 1'b0;
`endif
    set_chan8();
    for (int k = 0; k < 6; k++) if6.data_in[k*DW +: DW] = 32'h1000 + k;

    // Reset state (in_valid high during reset must be ignored).
    tick();
    if8.in_valid = 1'b1;
    tick();
    check_eq("rst_data_out", {32'd0, if8.data_out}, 64'd0);
    check_eq("rst_sel_err", {63'd0, if8.sel_err}, 64'd0);
    check_eq("rst_out_valid", {63'd0, if8.out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, if8.in_ready}, 64'd1);

    // Basic select: channel 5 one cycle after accept.
    reset_n = 1'b1;
    if8.selector = 3'd5; if8.out_ready = 1'b1;
    tick();
    check_eq("basic_data", {32'd0, if8.data_out}, 64'h1005);
    check_eq("basic_valid", {63'd0, if8.out_valid}, 64'd1);
    if8.in_valid = 1'b0;
    tick();

    // Backpressure: third request ignored while full.
    if8.out_ready = 1'b0; if8.in_valid = 1'b1;
    if8.selector = 3'd1; tick();
    if8.selector = 3'd2; tick();
    check_eq("bp_in_ready", {63'd0, if8.in_ready}, 64'd0);
    if8.selector = 3'd3; tick();
    check_eq("bp_hold", {32'd0, if8.data_out}, 64'h1001);
    if8.in_valid = 1'b0; if8.out_ready = 1'b1;
    tick();
    check_eq("bp_second", {32'd0, if8.data_out}, 64'h1002);
    tick();
    check_eq("bp_drained", {63'd0, if8.out_valid}, 64'd0);

    // Streaming: one word per cycle, in_ready stays high.
    if8.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if8.selector = 3'(i % 8);
      tick();
      check_eq("stream_data", {32'd0, if8.data_out}, 64'h1000 + 64'(i % 8));
    end
    if8.in_valid = 1'b0;
    tick();

    // Random traffic with random data and occasional resets.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 8; k++) if8.data_in[k*DW +: DW] = $urandom();
      if8.in_valid  = 1'($urandom_range(0, 1));
      if8.out_ready = ($urandom_range(0, 3) != 0);
      if8.selector  = 3'($urandom_range(0, 7));
      reset_n       = ($urandom_range(0, 63) != 0);
      tick();
    end
    reset_n = 1'b1;
    set_chan8();

    // Reset mid-operation from the full state.
    if8.in_valid = 1'b0; if8.out_ready = 1'b1;
    tick(); tick();
    if8.out_ready = 1'b0; if8.in_valid = 1'b1;
    if8.selector = 3'd6; tick();
    if8.selector = 3'd7; tick();
    check_eq("full_in_ready", {63'd0, if8.in_ready}, 64'd0);
    reset_n = 1'b0;
    tick();
    check_eq("midrst_valid", {63'd0, if8.out_valid}, 64'd0);
    check_eq("midrst_ready", {63'd0, if8.in_ready}, 64'd1);
    check_eq("midrst_data", {32'd0, if8.data_out}, 64'd0);
    reset_n = 1'b1;
    if8.selector = 3'd4; if8.out_ready = 1'b1;
    tick();
    check_eq("post_rst_data", {32'd0, if8.data_out}, 64'h1004);
    if8.in_valid = 1'b0;
    tick();

    // Out-of-range selectors on the 6-channel instance.
    if6.in_valid = 1'b1;
    if6.selector = 3'd7; tick();
    check_eq("oor7_data", {32'd0, if6.data_out}, 64'd227);
    check_eq("oor7_err", {63'd0, if6.sel_err}, 64'd1);
    if6.selector = 3'd2; tick();
    check_eq("in2_data", {32'd0, if6.data_out}, 64'h1002);
    check_eq("in2_err", {63'd0, if6.sel_err}, 64'd0);
    if6.selector = 3'd6; tick();
    check_eq("oor6_data", {32'd0, if6.data_out}, 64'd227);
    check_eq("oor6_err", {63'd0, if6.sel_err}, 64'd1);
    if6.selector = 3'd5; tick();
    check_eq("in5_data", {32'd0, if6.data_out}, 64'h1005);
    check_eq("in5_valid", {63'd0, if6.out_valid}, 64'd1);
    if6.in_valid = 1'b0;
    tick();

`ifdef MUX_PIPE_SCAN_EN
    // Scan mode: selector ignored, pointer walks 0..7 and wraps.
    scan_en = 1'b1; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if8.selector = 3'($urandom_range(0, 7));
      tick();
      check_eq("scan_data", {32'd0, if8.data_out}, 64'h1000 + 64'(i % 8));
      check_eq("scan_err", {63'd0, if8.sel_err}, 64'd0);
    end
    scan_en = 1'b0; if8.in_valid = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
